host_dma_scheduler: RTL and testbench

Job sequencer in front of the host DMA engine. It accepts a run command from the host register block and, when weights are not yet resident, issues a weight-load phase to DDR. It then issues the image phase and tracks completion through the engine's end-of-packet strobes and write responses. It reports busy, done and error status back to the host.

---
 rtl/host_dma_scheduler_if.sv | 34 +++
 rtl/host_dma_scheduler.sv | 83 ++++++++
 tb/tb_host_dma_scheduler.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/host_dma_scheduler_if.sv
// host_dma_scheduler_if: host command, engine kick/event, write-response and status signals
interface host_dma_scheduler_if;
  logic        cmd_start;
  logic        cmd_reload_weights;
  logic [31:0] cmd_image_num;
  logic        cmd_abort;
  logic        load_weights;
  logic        model_start;
  logic [31:0] image_num;
  logic        ddr_din_eop;
  logic        blob_dout_eop;
  logic        m_axi_bvalid;
  logic        m_axi_bready;
  logic [1:0]  m_axi_bresp;
  logic        busy;
  logic        done;
  logic        error;
  logic [1:0]  err_code;
  logic [31:0] images_done;
  logic        weights_resident;
  logic [2:0]  state_dbg;
  modport master (
    output cmd_start, cmd_reload_weights, cmd_image_num, cmd_abort, ddr_din_eop, blob_dout_eop,
           m_axi_bvalid, m_axi_bready, m_axi_bresp,
    input  load_weights, model_start, image_num, busy, done, error, err_code, images_done,
           weights_resident, state_dbg
  );
  modport slave (
    input  cmd_start, cmd_reload_weights, cmd_image_num, cmd_abort, ddr_din_eop, blob_dout_eop,
           m_axi_bvalid, m_axi_bready, m_axi_bresp,
    output load_weights, model_start, image_num, busy, done, error, err_code, images_done,
           weights_resident, state_dbg
  );
endinterface

// File: rtl/host_dma_scheduler.sv
// host_dma_scheduler: sequences the weight-load and image phases of the host DMA engine
module host_dma_scheduler #(
  parameter int OUT_BEATS_PER_IMAGE = 16,
  parameter int KICK_CYCLES = 4,
  parameter int TIMEOUT_WIDTH = 24
) (
  input logic clk,
  input logic m_axi_aresetn,
  host_dma_scheduler_if.slave bus
);
  localparam int KW = $clog2(KICK_CYCLES + 1);
  typedef enum logic [2:0] {
    IDLE = 3'd0, W_KICK = 3'd1, W_WAIT = 3'd2, M_KICK = 3'd3, M_RUN = 3'd4, DONE = 3'd5, ERR = 3'd6
  } state_t;
  state_t state, state_n;
  logic [KW-1:0] kcnt;
  logic [TIMEOUT_WIDTH-1:0] wd;
  logic [39:0] resp, resp_n, target;
  logic [31:0] img, img_n, imn, imn_n;
  logic [1:0] err, err_n;
  logic wr, wr_n, ms, hs, progress, start_acc, kick_last, watch, tmo;
  assign hs = bus.m_axi_bvalid & bus.m_axi_bready;
  assign progress = bus.ddr_din_eop | bus.blob_dout_eop | hs;
  assign start_acc = state == IDLE && bus.cmd_start && !bus.cmd_abort;
  assign kick_last = kcnt == KW'(KICK_CYCLES - 1);
  assign watch = state == W_WAIT || state == M_RUN;
  assign tmo = watch && wd == '0 && !progress;
  assign target = 40'(imn) * 40'(OUT_BEATS_PER_IMAGE);
  always_comb begin
    imn_n = start_acc ? bus.cmd_image_num : imn;
    img_n = start_acc ? '0 : (state == M_RUN && bus.blob_dout_eop && ~&img) ? img + 32'd1 : img;
    resp_n = start_acc ? '0 : (state == M_RUN && hs && ~&resp) ? resp + 40'd1 : resp;
    state_n = state;
    case (state)
      IDLE:    if (bus.cmd_start) state_n = (bus.cmd_reload_weights || !wr) ? W_KICK : M_KICK;
      W_KICK:  if (kick_last) state_n = W_WAIT;
      W_WAIT:  state_n = bus.ddr_din_eop ? M_KICK : tmo ? ERR : W_WAIT;
      M_KICK:  state_n = imn == '0 ? DONE : kick_last ? M_RUN : M_KICK;
      M_RUN:   state_n = (img_n == imn && resp_n == target) ? DONE : tmo ? ERR : M_RUN;
      default: state_n = IDLE;
    endcase
    if (bus.cmd_abort) state_n = ERR;
    err_n = start_acc ? 2'd0 : err;
    if (err_n == 2'd0)
      err_n = bus.cmd_abort ? 2'd3 : (hs && bus.m_axi_bresp != 2'd0) ? 2'd1 : tmo ? 2'd2 : 2'd0;
    // a failed or abandoned weight load leaves the engine's weights undefined
    wr_n = ((state == W_KICK || state == W_WAIT) && state_n == ERR) ? 1'b0 :
           (state == W_WAIT && bus.ddr_din_eop) ? 1'b1 : wr;
  end
  always_ff @(posedge clk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      state <= IDLE;
      kcnt <= '0;
      wd <= '1;
      resp <= '0;
      img <= '0;
      imn <= '0;
      err <= '0;
      wr <= 1'b0;
      ms <= 1'b0;
    end else begin
      state <= state_n;
      kcnt <= state_n == state ? kcnt + KW'(1) : '0;
      wd <= (!watch || progress) ? '1 : wd - TIMEOUT_WIDTH'(1);
      resp <= resp_n;
      img <= img_n;
      imn <= imn_n;
      err <= err_n;
      wr <= wr_n;
      ms <= state_n == M_KICK && imn_n != '0;
    end
  end
  assign bus.load_weights = state == W_KICK;
  assign bus.model_start = ms;
  assign bus.image_num = imn;
  assign bus.busy = state != IDLE;
  assign bus.done = state == DONE || state == ERR;
  assign bus.error = err != 2'd0;
  assign bus.err_code = err;
  assign bus.images_done = img;
  assign bus.weights_resident = wr;
  assign bus.state_dbg = state;
endmodule

// File: tb/tb_host_dma_scheduler.sv
// tb_host_dma_scheduler: directed jobs; expected done records and kick lengths are queued
// by the stimulus and checked by independent monitors
module tb_host_dma_scheduler;
  typedef struct {
    logic [1:0]  err;
    logic [31:0] img;
    logic        wr;
    logic [31:0] imn;
    int          dc;
  } exp_t;
  typedef struct {
    bit ms;
    int len;
  } kick_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  exp_t dq[$];
  kick_t kq[$];
  host_dma_scheduler_if b();
  host_dma_scheduler #(.OUT_BEATS_PER_IMAGE(16), .KICK_CYCLES(4), .TIMEOUT_WIDTH(8)) dut (
    .clk(clk),
    .m_axi_aresetn(rst_n),
    .bus(b)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push_done(input logic [1:0] e, input logic [31:0] i, input logic w,
                           input logic [31:0] m, input int d);
    exp_t x;
    x.err = e;
    x.img = i;
    x.wr = w;
    x.imn = m;
    x.dc = d;
    dq.push_back(x);
  endtask
  task automatic push_kick(input bit s, input int l);
    kick_t k;
    k.ms = s;
    k.len = l;
    kq.push_back(k);
  endtask
  task automatic start(input logic rl, input logic [31:0] n);
    b.cmd_start = 1'b1;
    b.cmd_reload_weights = rl;
    b.cmd_image_num = n;
    tick();
    b.cmd_start = 1'b0;
    b.cmd_reload_weights = 1'b0;
  endtask
  task automatic run_job(input int n, input int bad_idx, input logic [1:0] e);
    push_done(e, n, 1'b1, n, cyc + n * 16);
    for (int i = 0; i < n * 16; i++) begin
      b.m_axi_bvalid = 1'b1;
      b.m_axi_bready = 1'b1;
      b.m_axi_bresp = (i == bad_idx) ? 2'b10 : 2'b00;
      b.blob_dout_eop = (i % 16 == 15);
      tick();
    end
    b.m_axi_bvalid = 1'b0;
    b.m_axi_bready = 1'b0;
    b.m_axi_bresp = 2'b00;
    b.blob_dout_eop = 1'b0;
    repeat (2) tick();
  endtask
  task automatic cold(input int n, input int bad_idx, input logic [1:0] e);
    push_kick(1'b0, 4);
    push_kick(1'b1, 4);
    start(1'b0, n);
    repeat (5) tick();
    b.ddr_din_eop = 1'b1;
    tick();
    b.ddr_din_eop = 1'b0;
    repeat (4) tick();
    run_job(n, bad_idx, e);
  endtask
  task automatic warm(input int n, input int bad_idx, input logic [1:0] e);
    push_kick(1'b1, 4);
    start(1'b0, n);
    repeat (4) tick();
    run_job(n, bad_idx, e);
  endtask
  initial begin : done_mon
    exp_t e;
    forever begin
      @(negedge clk);
      if (b.done) begin
        if (dq.size() == 0) check("done_unexpected", 1, 0);
        else begin
          e = dq.pop_front();
          check("done_cycle", cyc, e.dc);
          check("err_code", b.err_code, e.err);
          check("error", b.error, e.err != 2'd0);
          check("images_done", b.images_done, e.img);
          check("weights_resident", b.weights_resident, e.wr);
          check("image_num", b.image_num, e.imn);
        end
        @(negedge clk);
        check("done_one_cycle", b.done, 0);
        check("busy_after_done", b.busy, 0);
      end
    end
  end
  initial begin : kick_mon
    int lc = 0;
    int mc = 0;
    kick_t k;
    forever begin
      @(negedge clk);
      if (b.load_weights) lc++;
      if (b.model_start) mc++;
      if ((!b.load_weights && lc > 0) || (!b.model_start && mc > 0)) begin
        if (kq.size() == 0) check("kick_unexpected", 1, 0);
        else begin
          k = kq.pop_front();
          check("kick_kind", !b.model_start && mc > 0, k.ms);
          check("kick_len", lc > 0 ? lc : mc, k.len);
        end
        if (!b.load_weights) lc = 0;
        if (!b.model_start) mc = 0;
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation did not finish");
  end
  initial begin
    b.cmd_start = 1'b0;
    b.cmd_reload_weights = 1'b0;
    b.cmd_image_num = 32'd0;
    b.cmd_abort = 1'b0;
    b.ddr_din_eop = 1'b0;
    b.blob_dout_eop = 1'b0;
    b.m_axi_bvalid = 1'b0;
    b.m_axi_bready = 1'b0;
    b.m_axi_bresp = 2'b00;
    repeat (3) tick();
    check("rst_status", {b.busy, b.done, b.error, b.err_code, b.weights_resident,
                         b.load_weights, b.model_start, b.state_dbg}, 0);
    check("rst_counts", {b.images_done, b.image_num}, 0);
    rst_n = 1'b1;
    repeat (2) tick();
    cold(2, -1, 2'd0);
    warm(1, -1, 2'd0);
    push_done(2'd0, 32'd0, 1'b1, 32'd0, cyc + 2);
    start(1'b0, 32'd0);
    repeat (3) tick();
    warm(1, 5, 2'd1);
    push_kick(1'b0, 4);
    push_done(2'd2, 32'd0, 1'b0, 32'd1, cyc + 261);
    start(1'b1, 32'd1);
    repeat (270) tick();
    check("wr_after_timeout", b.weights_resident, 0);
    cold(1, -1, 2'd0);
    push_kick(1'b1, 3);
    push_done(2'd3, 32'd0, 1'b1, 32'd3, cyc + 4);
    start(1'b0, 32'd3);
    repeat (2) tick();
    b.cmd_abort = 1'b1;
    tick();
    b.cmd_abort = 1'b0;
    check("ms_low_after_abort", b.model_start, 0);
    repeat (2) tick();
    warm(1, -1, 2'd0);
    push_done(2'd3, 32'd1, 1'b1, 32'd1, cyc + 1);
    b.cmd_start = 1'b1;
    b.cmd_abort = 1'b1;
    b.cmd_image_num = 32'd7;
    tick();
    b.cmd_start = 1'b0;
    b.cmd_abort = 1'b0;
    repeat (3) tick();
    push_done(2'd0, 32'd0, 1'b1, 32'd0, cyc + 2);
    start(1'b0, 32'd0);
    repeat (3) tick();
    push_kick(1'b1, 1);
    start(1'b0, 32'd5);
    tick();
    rst_n = 1'b0;
    #1;
    check("midjob_rst_busy", b.busy, 0);
    check("midjob_rst_wr", b.weights_resident, 0);
    check("midjob_rst_ms", b.model_start, 0);
    check("midjob_rst_state", b.state_dbg, 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 50 && (dq.size() != 0 || kq.size() != 0); i++) tick();
    check("done_queue_drained", dq.size(), 0);
    check("kick_queue_drained", kq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
